// File: rtl/if_id_stage_if.sv
// IF/ID boundary bundle: fetch-side inputs, ID-side outputs and fetch hold/bubble controls.
// Counter signals exist only when IF_ID_PERF_EN is defined.
interface if_id_stage_if;
    logic [31:0] PC_if;
    logic [31:0] Instruction_if;
    logic        IF_flush;
    logic        MemRead_ex;
    logic [4:0]  RegWriteAddr_ex;
    logic [31:0] PC_id;
    logic [31:0] Instruction_id;
    logic        Valid_id;
    logic        IFWrite;
    logic        ID_bubble;
`ifdef IF_ID_PERF_EN
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
`endif

    // Pipeline environment side: drives fetch/EX info, observes ID slot and controls
    modport master (
        output PC_if, Instruction_if, IF_flush, MemRead_ex, RegWriteAddr_ex,
        input  PC_id, Instruction_id, Valid_id, IFWrite, ID_bubble
`ifdef IF_ID_PERF_EN
        , input StallCount, FlushCount
`endif
    );

    // IF/ID stage side
    modport slave (
        input  PC_if, Instruction_if, IF_flush, MemRead_ex, RegWriteAddr_ex,
        output PC_id, Instruction_id, Valid_id, IFWrite, ID_bubble
`ifdef IF_ID_PERF_EN
        , output StallCount, FlushCount
`endif
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush-to-NOP, load-use hazard detection and multi-cycle stall FSM.
// Optional IF_ID_PERF_EN adds free-running StallCount/FlushCount outputs.
module if_id_stage #(
    parameter int unsigned STALL_CYCLES = 1
) (
    input logic            clk,
    input logic            reset,
    if_id_stage_if.slave   bus
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(STALL_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] pc_q, instr_q;
    logic        valid_q;
    logic [4:0]  rs, rt;
    logic        hazard;
    logic        stall;

    assign rs = instr_q[25:21];
    assign rt = instr_q[20:16];

    assign hazard = valid_q & bus.MemRead_ex & (bus.RegWriteAddr_ex != 5'd0) &
                    ((bus.RegWriteAddr_ex == rs) | (bus.RegWriteAddr_ex == rt));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // With a single stall cycle the RUN-state hazard itself is the whole stall
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (hazard && (STALL_CYCLES > 1)) begin
                    state_nxt = STALL;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            STALL: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1)
                    state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        stall = ((state == RUN) && hazard) || (state == STALL);
        bus.IFWrite   = ~stall;
        bus.ID_bubble = stall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (stall) begin
            pc_q    <= pc_q;
            instr_q <= instr_q;
            valid_q <= valid_q;
        end else if (bus.IF_flush) begin
            pc_q    <= bus.PC_if;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= bus.PC_if;
            instr_q <= bus.Instruction_if;
            valid_q <= 1'b1;
        end
    end

    assign bus.PC_id          = pc_q;
    assign bus.Instruction_id = instr_q;
    assign bus.Valid_id       = valid_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_count, flush_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall)
                stall_count <= stall_count + 32'd1;
            if (bus.IF_flush && !stall)
                flush_count <= flush_count + 32'd1;
        end
    end

    assign bus.StallCount = stall_count;
    assign bus.FlushCount = flush_count;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: one instance with STALL_CYCLES=1 (b1/u1) and one with 2 (b2/u2),
// both fed identical stimulus; each test resets first.
module tb_if_id_stage;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    if_id_stage_if b1 ();
    if_id_stage_if b2 ();

    if_id_stage u1 (.clk(clk), .reset(reset), .bus(b1));
    if_id_stage #(.STALL_CYCLES(2)) u2 (.clk(clk), .reset(reset), .bus(b2));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic [31:0] pc, input logic [31:0] ins, input logic fl,
                          input logic mr, input logic [4:0] rwa);
        b1.PC_if = pc;  b1.Instruction_if = ins;  b1.IF_flush = fl;
        b1.MemRead_ex = mr;  b1.RegWriteAddr_ex = rwa;
        b2.PC_if = pc;  b2.Instruction_if = ins;  b2.IF_flush = fl;
        b2.MemRead_ex = mr;  b2.RegWriteAddr_ex = rwa;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in('0, '0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in($urandom, $urandom, 1'b0, 1'b1, 5'($urandom_range(1, 31)));
        #1;
        vectors++; if (b1.PC_id !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want %h", b1.PC_id, 32'h0); end
        vectors++; if (b1.Instruction_id !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h want %h", b1.Instruction_id, 32'h0); end
        vectors++; if (b1.Valid_id !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", b1.Valid_id); end
        vectors++; if (b1.IFWrite !== 1'b1) begin miscompares++; $display("FAIL rst_ifwrite: got %b want 1", b1.IFWrite); end
        vectors++; if (b1.ID_bubble !== 1'b0) begin miscompares++; $display("FAIL rst_bubble: got %b want 0", b1.ID_bubble); end
        set_in($urandom, $urandom, 1'b0, 1'b1, 5'($urandom_range(1, 31)));
        tick();
        vectors++; if (b1.PC_id !== 32'h0 || b1.Valid_id !== 1'b0) begin miscompares++; $display("FAIL rst_held: got pc=%h v=%b want pc=0 v=0", b1.PC_id, b1.Valid_id); end
        vectors++; if (b2.IFWrite !== 1'b1) begin miscompares++; $display("FAIL rst_ifwrite2: got %b want 1", b2.IFWrite); end
        set_in(32'h4, 32'h8C010000, 1'b0, 1'b0, '0);
        reset = 1'b1;
        tick();
        vectors++; if (b1.PC_id !== 32'h4) begin miscompares++; $display("FAIL rel_pc: got %h want %h", b1.PC_id, 32'h4); end
        vectors++; if (b1.Instruction_id !== 32'h8C010000) begin miscompares++; $display("FAIL rel_instr: got %h want %h", b1.Instruction_id, 32'h8C010000); end
        vectors++; if (b1.Valid_id !== 1'b1) begin miscompares++; $display("FAIL rel_valid: got %b want 1", b1.Valid_id); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(32'h10, 32'h00221820, 1'b0, 1'b0, '0);
        tick();
        set_in(32'h14, 32'h11111111, 1'b0, 1'b1, 5'd1);
        #1;
        vectors++; if (b1.IFWrite !== 1'b0) begin miscompares++; $display("FAIL lu_ifwrite: got %b want 0", b1.IFWrite); end
        vectors++; if (b1.ID_bubble !== 1'b1) begin miscompares++; $display("FAIL lu_bubble: got %b want 1", b1.ID_bubble); end
        tick();
        vectors++; if (b1.PC_id !== 32'h10 || b1.Instruction_id !== 32'h00221820 || b1.Valid_id !== 1'b1) begin
            miscompares++; $display("FAIL lu_hold: got pc=%h ins=%h v=%b want pc=00000010 ins=00221820 v=1", b1.PC_id, b1.Instruction_id, b1.Valid_id); end
        b1.MemRead_ex = 1'b0; b2.MemRead_ex = 1'b0;
        #1;
        vectors++; if (b1.IFWrite !== 1'b1 || b1.ID_bubble !== 1'b0) begin miscompares++; $display("FAIL lu_release: got ifw=%b bub=%b want ifw=1 bub=0", b1.IFWrite, b1.ID_bubble); end
        tick();
        vectors++; if (b1.PC_id !== 32'h14 || b1.Instruction_id !== 32'h11111111) begin miscompares++; $display("FAIL lu_advance: got pc=%h ins=%h want pc=00000014 ins=11111111", b1.PC_id, b1.Instruction_id); end
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        set_in(32'h18, 32'h00021820, 1'b0, 1'b0, '0);   // add $3,$0,$2: rs=0 rt=2
        tick();
        set_in(32'h1C, 32'h0, 1'b0, 1'b1, 5'd0);
        #1;
        vectors++; if (b1.IFWrite !== 1'b1) begin miscompares++; $display("FAIL nf_r0: got %b want 1", b1.IFWrite); end
        set_in(32'h1C, 32'h0, 1'b0, 1'b0, 5'd2);
        #1;
        vectors++; if (b1.IFWrite !== 1'b1) begin miscompares++; $display("FAIL nf_noload: got %b want 1", b1.IFWrite); end
        set_in(32'h1C, 32'h0, 1'b0, 1'b1, 5'd5);
        #1;
        vectors++; if (b1.IFWrite !== 1'b1) begin miscompares++; $display("FAIL nf_nomatch: got %b want 1", b1.IFWrite); end
        set_in(32'h1C, 32'h0, 1'b0, 1'b1, 5'd2);
        #1;
        vectors++; if (b1.IFWrite !== 1'b0 || b1.ID_bubble !== 1'b1) begin miscompares++; $display("FAIL nf_rt_match: got ifw=%b bub=%b want ifw=0 bub=1", b1.IFWrite, b1.ID_bubble); end
        set_in(32'h1C, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_flush();
        do_reset();
        set_in(32'h8, 32'h00221820, 1'b0, 1'b0, '0);
        tick();
        set_in(32'h20, 32'hDEADBEEF, 1'b1, 1'b0, '0);
        tick();
        set_in(32'h24, 32'h0, 1'b0, 1'b0, '0);
        vectors++; if (b1.Instruction_id !== 32'h0) begin miscompares++; $display("FAIL fl_instr: got %h want %h", b1.Instruction_id, 32'h0); end
        vectors++; if (b1.Valid_id !== 1'b0) begin miscompares++; $display("FAIL fl_valid: got %b want 0", b1.Valid_id); end
        vectors++; if (b1.PC_id !== 32'h20) begin miscompares++; $display("FAIL fl_pc: got %h want %h", b1.PC_id, 32'h20); end
        vectors++; if (b1.IFWrite !== 1'b1) begin miscompares++; $display("FAIL fl_ifwrite: got %b want 1", b1.IFWrite); end
        // A flushed slot never hazards, even on a matching load
        set_in(32'h24, 32'h0, 1'b0, 1'b1, 5'd1);
        #1;
        vectors++; if (b1.IFWrite !== 1'b1) begin miscompares++; $display("FAIL fl_nohaz: got %b want 1", b1.IFWrite); end
        set_in(32'h24, 32'h0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_in(32'h30, 32'h00221820, 1'b0, 1'b0, '0);
        tick();
        set_in(32'h40, 32'h22222222, 1'b1, 1'b1, 5'd2);
        #1;
        vectors++; if (b1.ID_bubble !== 1'b1 || b1.IFWrite !== 1'b0) begin miscompares++; $display("FAIL sim_ctrl: got bub=%b ifw=%b want bub=1 ifw=0", b1.ID_bubble, b1.IFWrite); end
        tick();
        vectors++; if (b1.PC_id !== 32'h30 || b1.Instruction_id !== 32'h00221820 || b1.Valid_id !== 1'b1) begin
            miscompares++; $display("FAIL sim_hold: got pc=%h ins=%h v=%b want pc=00000030 ins=00221820 v=1", b1.PC_id, b1.Instruction_id, b1.Valid_id); end
        set_in(32'h40, 32'h0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3] = '{32'h100, 32'h104, 32'h108};
        logic [31:0] ins [3] = '{32'h8C220004, 32'hAC430008, 32'h00851020};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(pcs[i], ins[i], 1'b0, 1'b0, '0);
            tick();
            vectors++; if (b1.PC_id !== pcs[i] || b1.Instruction_id !== ins[i] || b1.Valid_id !== 1'b1) begin
                miscompares++; $display("FAIL b2b_%0d: got pc=%h ins=%h v=%b want pc=%h ins=%h v=1", i, b1.PC_id, b1.Instruction_id, b1.Valid_id, pcs[i], ins[i]); end
        end
    endtask

    task automatic test_stall2();
        do_reset();
        set_in(32'h50, 32'h00221820, 1'b0, 1'b0, '0);
        tick();
        set_in(32'h54, 32'h33333333, 1'b0, 1'b1, 5'd1);
        #1;
        vectors++; if (b2.IFWrite !== 1'b0) begin miscompares++; $display("FAIL s2_c1: got %b want 0", b2.IFWrite); end
        tick();
        set_in(32'h54, 32'h33333333, 1'b0, 1'b0, '0);
        #1;
        vectors++; if (b2.IFWrite !== 1'b0 || b2.ID_bubble !== 1'b1) begin miscompares++; $display("FAIL s2_c2: got ifw=%b bub=%b want ifw=0 bub=1", b2.IFWrite, b2.ID_bubble); end
        vectors++; if (b1.IFWrite !== 1'b1) begin miscompares++; $display("FAIL s1_c2: got %b want 1", b1.IFWrite); end
        vectors++; if (b2.PC_id !== 32'h50) begin miscompares++; $display("FAIL s2_hold: got %h want %h", b2.PC_id, 32'h50); end
        tick();
        vectors++; if (b2.IFWrite !== 1'b1) begin miscompares++; $display("FAIL s2_c3: got %b want 1", b2.IFWrite); end
        vectors++; if (b2.PC_id !== 32'h50) begin miscompares++; $display("FAIL s2_hold2: got %h want %h", b2.PC_id, 32'h50); end
`ifdef IF_ID_PERF_EN
        vectors++; if (b2.StallCount !== 32'd2) begin miscompares++; $display("FAIL s2_stallcnt: got %0d want 2", b2.StallCount); end
        set_in(32'h60, 32'h0, 1'b1, 1'b0, '0);
        tick();
        vectors++; if (b2.FlushCount !== 32'd1) begin miscompares++; $display("FAIL s2_flushcnt: got %0d want 1", b2.FlushCount); end
        set_in(32'h64, 32'h00221820, 1'b0, 1'b0, '0);
        tick();
        set_in(32'h68, 32'h0, 1'b1, 1'b1, 5'd1);
        tick();
        set_in(32'h68, 32'h0, 1'b1, 1'b0, '0);
        tick();
        set_in(32'h6C, 32'h0, 1'b0, 1'b0, '0);
        vectors++; if (b2.FlushCount !== 32'd1) begin miscompares++; $display("FAIL s2_flushstall: got %0d want 1", b2.FlushCount); end
        vectors++; if (b2.StallCount !== 32'd4) begin miscompares++; $display("FAIL s2_stallcnt2: got %0d want 4", b2.StallCount); end
`endif
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_in(32'h70, 32'h00221820, 1'b0, 1'b0, '0);
        tick();
        set_in(32'h74, 32'h44444444, 1'b0, 1'b1, 5'd1);
        tick();
        set_in(32'h74, 32'h44444444, 1'b0, 1'b0, '0);
        #1;
        vectors++; if (b2.IFWrite !== 1'b0) begin miscompares++; $display("FAIL rms_pre: got %b want 0", b2.IFWrite); end
        reset = 1'b0;
        #1;
        vectors++; if (b2.IFWrite !== 1'b1 || b2.ID_bubble !== 1'b0) begin miscompares++; $display("FAIL rms_async: got ifw=%b bub=%b want ifw=1 bub=0", b2.IFWrite, b2.ID_bubble); end
        tick();
        reset = 1'b1;
        #1;
        vectors++; if (b2.IFWrite !== 1'b1) begin miscompares++; $display("FAIL rms_run: got %b want 1", b2.IFWrite); end
        tick();
        vectors++; if (b2.PC_id !== 32'h74 || b2.Instruction_id !== 32'h44444444 || b2.Valid_id !== 1'b1) begin
            miscompares++; $display("FAIL rms_load: got pc=%h ins=%h v=%b want pc=00000074 ins=44444444 v=1", b2.PC_id, b2.Instruction_id, b2.Valid_id); end
    endtask

    initial begin
        set_in('0, '0, 1'b0, 1'b0, '0);
        #3;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_flush();
        test_simultaneous();
        test_back_to_back();
        test_stall2();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
